// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA priority/arbitration block.
// Holds the FSM state encoding, transfer-mode codes and the release rule.
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_REQ = 2'd1,
    ST_SERVICE  = 2'd2,
    ST_RELEASE  = 2'd3
  } dma_state_t;

  localparam logic [1:0] MODE_DEMAND     = 2'b00;
  localparam logic [1:0] MODE_SINGLE     = 2'b01;
  localparam logic [1:0] MODE_BLOCK      = 2'b10;
  localparam logic [1:0] MODE_SINGLE_ALT = 2'b11;

  // End-of-service decision for the channel currently holding the bus.
  function automatic logic release_hit(input logic [1:0] mode,
                                       input logic       xfer_done,
                                       input logic       eop,
                                       input logic       ch_valid);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_DEMAND:     hit = eop | (xfer_done & ~ch_valid);
      MODE_BLOCK:      hit = eop;
      MODE_SINGLE,
      MODE_SINGLE_ALT: hit = xfer_done;
      default:         hit = xfer_done;
    endcase
    return hit | (eop & xfer_done);
  endfunction

endpackage

// File: rtl/dma_pri_encoder.sv
// Combinational rotating priority encoder: the channel at 'pointer' is
// highest priority, then pointer+1, and so on modulo the channel count.
module dma_pri_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] valid,
  input  logic [1:0]        pointer,
  output logic [1:0]        winner,
  output logic              any
);

  logic [NUM_CH-1:0] rotated;
  logic [1:0]        offset;

  // rotated[k] is the request of the channel k places below the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
      assign rotated[gi] = valid[pointer + 2'(gi)];
    end
  endgenerate

  always_comb begin
    offset = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rotated[i]) offset = 2'(i);
    end
    winner = pointer + offset;
    any    = |valid;
  end

endmodule

// File: rtl/dma_priority.sv
// DMA request arbitration: samples channel requests, negotiates the bus
// with the CPU via HRQ/HLDA and issues a one-hot DACK to the winner.
module dma_priority
  import dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  DREQ,
  input  logic        HLDA,
  input  logic [3:0]  sw_req,
  input  logic [3:0]  mask,
  input  logic [7:0]  mode_xfer,
  input  logic        cmd_disable,
  input  logic        cmd_rot_pri,
  input  logic        cmd_dreq_low,
  input  logic        cmd_dack_high,
  input  logic        xfer_done,
  input  logic        eop,
  output logic        HRQ,
  output logic [3:0]  DACK,
  output logic        svc_active,
  output logic [1:0]  svc_ch
);

  dma_state_t state, state_next;
  logic [3:0] dreq_q;
  logic       hrq_q, hrq_next;
  logic [3:0] dack_q, dack_next;
  logic       active_q, active_next;
  logic [1:0] ch_q, ch_next;
  logic [1:0] ptr_q, ptr_next;

  logic [3:0] valid;
  logic [1:0] winner;
  logic       any;
  logic [1:0] ch_mode;

  // Software requests bypass both the mask and the polarity control.
  assign valid   = ((dreq_q ^ {4{cmd_dreq_low}}) & ~mask) | sw_req;
  assign ch_mode = mode_xfer[{ch_q, 1'b0} +: 2];

  dma_pri_encoder u_enc (
    .valid   (valid),
    .pointer (cmd_rot_pri ? ptr_q : 2'd0),
    .winner  (winner),
    .any     (any)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      dreq_q   <= 4'd0;
      hrq_q    <= 1'b0;
      dack_q   <= 4'd0;
      active_q <= 1'b0;
      ch_q     <= 2'd0;
      ptr_q    <= 2'd0;
    end else begin
      state    <= state_next;
      dreq_q   <= DREQ;
      hrq_q    <= hrq_next;
      dack_q   <= dack_next;
      active_q <= active_next;
      ch_q     <= ch_next;
      ptr_q    <= ptr_next;
    end
  end

  always_comb begin
    state_next  = state;
    hrq_next    = hrq_q;
    dack_next   = dack_q;
    active_next = active_q;
    ch_next     = ch_q;
    ptr_next    = ptr_q;
    case (state)
      ST_IDLE: begin
        if (any && !cmd_disable) begin
          state_next = ST_HOLD_REQ;
          hrq_next   = 1'b1;
        end
      end
      ST_HOLD_REQ: begin
        if (HLDA && any) begin
          state_next  = ST_SERVICE;
          ch_next     = winner;
          dack_next   = 4'b0001 << winner;
          active_next = 1'b1;
        end else if (!any) begin
          state_next = ST_IDLE;
          hrq_next   = 1'b0;
        end
      end
      ST_SERVICE: begin
        // Losing HLDA aborts without crediting the channel to the rotation.
        if (!HLDA) begin
          state_next  = ST_IDLE;
          hrq_next    = 1'b0;
          dack_next   = 4'd0;
          active_next = 1'b0;
        end else if (release_hit(ch_mode, xfer_done, eop, valid[ch_q])) begin
          state_next  = ST_RELEASE;
          hrq_next    = 1'b0;
          dack_next   = 4'd0;
          active_next = 1'b0;
          ptr_next    = ch_q + 2'd1;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign HRQ        = hrq_q;
  assign DACK       = dack_q ^ {4{~cmd_dack_high}};
  assign svc_active = active_q;
  assign svc_ch     = ch_q;

endmodule

// File: tb/tb_dma_priority.sv
// Directed bench for dma_priority with a cycle-level behavioural model
// compared on every falling edge, plus literal checks per scenario.
module tb_dma_priority;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = 4'd0;
  logic       HLDA = 1'b0;
  logic [3:0] sw_req = 4'd0;
  logic [3:0] mask = 4'd0;
  logic [7:0] mode_xfer = 8'b01010101;
  logic       cmd_disable = 1'b0;
  logic       cmd_rot_pri = 1'b0;
  logic       cmd_dreq_low = 1'b0;
  logic       cmd_dack_high = 1'b0;
  logic       xfer_done = 1'b0;
  logic       eop = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic       svc_active;
  logic [1:0] svc_ch;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  dma_priority dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .sw_req(sw_req),
    .mask(mask), .mode_xfer(mode_xfer), .cmd_disable(cmd_disable),
    .cmd_rot_pri(cmd_rot_pri), .cmd_dreq_low(cmd_dreq_low),
    .cmd_dack_high(cmd_dack_high), .xfer_done(xfer_done), .eop(eop),
    .HRQ(HRQ), .DACK(DACK), .svc_active(svc_active), .svc_ch(svc_ch)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_ASK = 1, P_OWN = 2, P_GAP = 3;
  int         m_phase = P_IDLE;
  logic       m_hrq = 1'b0;
  logic       m_active = 1'b0;
  logic       m_ack = 1'b0;
  int         m_ch = 0;
  int         m_ptr = 0;
  logic [3:0] m_dreq = 4'd0;

  function automatic int pick(input logic [3:0] v, input int start);
    for (int k = 0; k < 4; k++)
      if (v[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  function automatic bit done_now(input logic [1:0] md, input bit still);
    if (eop && xfer_done) return 1'b1;
    if (md == 2'b00) return eop || (xfer_done && !still);
    if (md == 2'b10) return eop;
    return xfer_done;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase = P_IDLE; m_hrq = 0; m_active = 0; m_ack = 0;
      m_ch = 0; m_ptr = 0; m_dreq = 4'd0;
    end else begin
      logic [3:0] v;
      v = ((m_dreq ^ {4{cmd_dreq_low}}) & ~mask) | sw_req;
      if (m_phase == P_IDLE) begin
        if (v != 0 && !cmd_disable) begin m_phase = P_ASK; m_hrq = 1; end
      end else if (m_phase == P_ASK) begin
        if (HLDA && v != 0) begin
          m_ch = pick(v, cmd_rot_pri ? m_ptr : 0);
          m_phase = P_OWN; m_active = 1; m_ack = 1;
        end else if (v == 0) begin
          m_phase = P_IDLE; m_hrq = 0;
        end
      end else if (m_phase == P_OWN) begin
        if (!HLDA) begin
          m_phase = P_IDLE; m_hrq = 0; m_active = 0; m_ack = 0;
        end else if (done_now(mode_xfer[2*m_ch +: 2], v[m_ch])) begin
          m_phase = P_GAP; m_hrq = 0; m_active = 0; m_ack = 0;
          m_ptr = (m_ch + 1) % 4;
        end
      end else begin
        m_phase = P_IDLE;
      end
      m_dreq = DREQ;
    end
  end

  always @(negedge CLK) begin
    if (run && !RESET) begin
      logic [3:0] exp_dack;
      exp_dack = (m_ack ? (4'b0001 << m_ch) : 4'b0000) ^ {4{~cmd_dack_high}};
      checks++;
      if (HRQ !== m_hrq || DACK !== exp_dack || svc_active !== m_active ||
          svc_ch !== 2'(m_ch)) begin
        errors++;
        $display("FAIL model t=%0t actual hrq=%b dack=%b act=%b ch=%0d required hrq=%b dack=%b act=%b ch=%0d",
                 $time, HRQ, DACK, svc_active, svc_ch, m_hrq, exp_dack, m_active, m_ch);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic wait_hrq(input string nm);
    for (int i = 0; i < 20 && HRQ !== 1'b1; i++) tick(1);
    chk(nm, 32'(HRQ), 32'd1);
  endtask

  task automatic serve_single(input logic [1:0] exp_ch, input string nm);
    wait_hrq({nm, "_hrq"});
    HLDA = 1'b1;
    tick(1);
    chk({nm, "_ch"}, 32'(svc_ch), 32'(exp_ch));
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0;
    HLDA = 1'b0;
    chk({nm, "_rel"}, 32'({HRQ, svc_active}), 32'd0);
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(1);
    RESET = 1'b0;
    run = 1'b1;
    chk("reset_hrq", 32'(HRQ), 32'd0);
    chk("reset_dack", 32'(DACK), 32'hF);
    chk("reset_act", 32'(svc_active), 32'd0);
    chk("reset_ch", 32'(svc_ch), 32'd0);

    // Fixed priority, HLDA two cycles after HRQ
    DREQ = 4'b1010;
    tick(1);
    chk("fix_hrq_early", 32'(HRQ), 32'd0);
    tick(1);
    chk("fix_hrq", 32'(HRQ), 32'd1);
    tick(2);
    HLDA = 1'b1;
    tick(1);
    chk("fix_ch", 32'(svc_ch), 32'd1);
    chk("fix_dack", 32'(DACK), 32'b1101);
    chk("fix_act", 32'(svc_active), 32'd1);
    xfer_done = 1'b1; DREQ = 4'd0;
    tick(1);
    xfer_done = 1'b0; HLDA = 1'b0;
    chk("fix_rel", 32'({HRQ, DACK}), 32'h0F);
    tick(3);

    // Rotating priority
    do_reset();
    cmd_rot_pri = 1'b1;
    DREQ = 4'b1001;
    serve_single(2'd0, "rot_a");
    serve_single(2'd3, "rot_b");
    serve_single(2'd0, "rot_c");
    serve_single(2'd3, "rot_d");
    DREQ = 4'b1111;
    serve_single(2'd0, "rot_e");
    serve_single(2'd1, "rot_f");
    serve_single(2'd2, "rot_g");
    serve_single(2'd3, "rot_h");
    DREQ = 4'd0;
    tick(3);

    // Block mode on ch2, then single-cycle RELEASE gap
    cmd_rot_pri = 1'b0;
    do_reset();
    mode_xfer = 8'b01_10_01_01;
    DREQ = 4'b0100;
    wait_hrq("blk_hrq");
    HLDA = 1'b1;
    tick(1);
    chk("blk_ch", 32'(svc_ch), 32'd2);
    for (int i = 0; i < 5; i++) begin
      xfer_done = 1'b1;
      tick(1);
      xfer_done = 1'b0;
      chk("blk_dack_hold", 32'(DACK), 32'b1011);
      tick(1);
    end
    eop = 1'b1;
    tick(1);
    eop = 1'b0; HLDA = 1'b0;
    chk("blk_rel", 32'({HRQ, DACK}), 32'h0F);
    tick(1);
    chk("blk_gap", 32'(HRQ), 32'd0);
    tick(1);
    chk("blk_rearm", 32'(HRQ), 32'd1);
    DREQ = 4'd0;
    tick(1);
    chk("blk_hold_req", 32'(HRQ), 32'd1);
    tick(1);
    chk("blk_withdraw", 32'(HRQ), 32'd0);
    mode_xfer = 8'b01010101;
    tick(2);

    // HLDA lost in the third SERVICE cycle
    do_reset();
    cmd_rot_pri = 1'b1;
    DREQ = 4'b0001;
    serve_single(2'd0, "abt_pre");
    DREQ = 4'b0110;
    wait_hrq("abt_hrq");
    HLDA = 1'b1;
    tick(1);
    chk("abt_ch", 32'(svc_ch), 32'd1);
    tick(2);
    HLDA = 1'b0;
    tick(1);
    chk("abt_out", 32'({HRQ, DACK, svc_active}), 32'b0_1111_0);
    chk("abt_ch_hold", 32'(svc_ch), 32'd1);
    serve_single(2'd1, "abt_ptr_kept");
    serve_single(2'd2, "abt_next");
    DREQ = 4'd0;
    cmd_rot_pri = 1'b0;
    tick(3);

    // Masking and software requests
    do_reset();
    mask = 4'b0010; DREQ = 4'b0010;
    tick(4);
    chk("mask_block", 32'(HRQ), 32'd0);
    sw_req = 4'b0010;
    tick(1);
    chk("swreq_hrq", 32'(HRQ), 32'd1);
    sw_req = 4'd0;
    tick(3);
    chk("swreq_off", 32'(HRQ), 32'd0);
    mask = 4'd0; DREQ = 4'd0;
    tick(2);

    // Demand mode on ch0
    do_reset();
    mode_xfer = 8'b01_01_01_00;
    DREQ = 4'b0001;
    wait_hrq("dem_hrq");
    HLDA = 1'b1;
    tick(1);
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0;
    chk("dem_stay", 32'(svc_active), 32'd1);
    DREQ = 4'd0;
    tick(1);
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0; HLDA = 1'b0;
    chk("dem_rel", 32'(svc_active), 32'd0);
    mode_xfer = 8'b01010101;
    tick(3);

    // Disable blocks new requests but not an ongoing service
    cmd_disable = 1'b1; sw_req = 4'b0001;
    tick(3);
    chk("dis_block", 32'(HRQ), 32'd0);
    cmd_disable = 1'b0;
    wait_hrq("dis_hrq");
    HLDA = 1'b1;
    tick(1);
    cmd_disable = 1'b1; sw_req = 4'd0;
    tick(2);
    chk("dis_keep", 32'(svc_active), 32'd1);
    xfer_done = 1'b1;
    tick(1);
    xfer_done = 1'b0; HLDA = 1'b0; cmd_disable = 1'b0;
    chk("dis_rel", 32'(svc_active), 32'd0);
    tick(2);

    // Active-low DREQ, active-high DACK
    mask = 4'hF;
    DREQ = 4'hF;
    tick(2);
    cmd_dreq_low = 1'b1; mask = 4'd0;
    tick(3);
    chk("low_idle", 32'(HRQ), 32'd0);
    DREQ = 4'b1011;
    wait_hrq("low_hrq");
    HLDA = 1'b1; cmd_dack_high = 1'b1;
    tick(1);
    chk("low_dack", 32'({svc_ch, DACK}), 32'b10_0100);
    HLDA = 1'b0;
    tick(1);
    DREQ = 4'd0; cmd_dreq_low = 1'b0; cmd_dack_high = 1'b0;
    do_reset();
    tick(1);

    // Asynchronous reset during SERVICE
    DREQ = 4'b0001;
    wait_hrq("ars_hrq");
    HLDA = 1'b1;
    tick(1);
    chk("ars_pre", 32'(svc_active), 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("ars_out", 32'({HRQ, DACK, svc_active}), 32'b0_1111_0);
    @(posedge CLK);
    #2;
    HLDA = 1'b0; DREQ = 4'd0;
    RESET = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
